// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB-lite round-robin arbiter: transfer-type
// encodings, arbiter state enum and a one-hot to index helper.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        PARK = 2'd0,
        OWN  = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    // Index of the set bit of a one-hot vector (up to 8 masters).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Combinational round-robin picker: searches requesters starting one above
// the pointer, wrapping, ignoring masked bits. Returns valid plus a one-hot
// winner.
module rr_picker #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N-1:0]     mask,
    output logic             valid,
    output logic [N-1:0]     winner
);

    logic [N-1:0]   req_eff;
    logic [PTR_W:0] shift;
    logic [2*N-1:0] rot_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;
    logic [2*N-1:0] back_dbl;
    logic           found;

    assign req_eff = req & ~mask;
    assign valid   = |req_eff;
    assign shift   = {1'b0, ptr} + (PTR_W+1)'(1);

    // Rotate so bit 0 is master ptr+1, take lowest set bit, rotate back.
    always_comb begin
        rot_dbl  = {req_eff, req_eff} >> shift;
        rot      = rot_dbl[N-1:0];
        first    = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (rot[k] && !found) begin
                first[k] = 1'b1;
                found    = 1'b1;
            end
        end
        back_dbl = {first, first} << shift;
        winner   = back_dbl[2*N-1:N];
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-lite round-robin arbiter with bus parking on master 0, locked-sequence
// support and no re-arbitration inside bursts.
// Optional macro ARB_TENURE_LIMIT_EN builds a per-tenure beat counter that
// forces the owner off the bus after TENURE_MAX active beats.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned MASTER_ID_W = 2,
    parameter int unsigned TENURE_MAX  = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_ID_W-1:0] HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1);

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [MASTER_ID_W-1:0] last, last_nxt;
    logic [MASTER_ID_W-1:0] pick_idx;
    logic [NUM_MASTERS-1:0] pick_mask;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic                   pick_valid;
    logic                   owner_req;
    logic                   owner_locked;
    logic                   owner_keep;
    logic                   boundary;
    logic                   arbitrate;
    logic                   limit_hit;

    assign HGRANT       = grant;
    assign owner_req    = |(HBUSREQ & grant);
    assign owner_locked = |(HLOCK & HBUSREQ & grant);
    assign boundary     = (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ) || !owner_req;
    // The owner is excluded from the first search pass so it only keeps the
    // bus when nobody else asks; a parked master 0 is not an owner.
    assign pick_mask    = (state == PARK) ? '0 : grant;
    assign owner_keep   = (state != PARK) && owner_req && !limit_hit;
    assign pick_idx     = MASTER_ID_W'(onehot_to_idx(8'(pick_oh)));

    rr_picker #(
        .N     (NUM_MASTERS),
        .PTR_W (MASTER_ID_W)
    ) u_picker (
        .req    (HBUSREQ),
        .ptr    (last),
        .mask   (pick_mask),
        .valid  (pick_valid),
        .winner (pick_oh)
    );

`ifdef ARB_TENURE_LIMIT_EN
    localparam int unsigned TEN_W = $clog2(TENURE_MAX + 1);

    logic [TEN_W-1:0] tenure_cnt;

    assign limit_hit = (state == OWN) && (tenure_cnt == TEN_W'(TENURE_MAX));

    // Count active beats of the current owner; clear on every grant change.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tenure_cnt <= '0;
        end else if (HREADY) begin
            if (grant_nxt != grant) begin
                tenure_cnt <= '0;
            end else if ((state == OWN) &&
                         ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                         (tenure_cnt != TEN_W'(TENURE_MAX))) begin
                tenure_cnt <= tenure_cnt + TEN_W'(1);
            end
        end
    end
`else
    assign limit_hit = 1'b0;

    // TENURE_MAX only sizes the tenure counter, which this build omits.
    if (TENURE_MAX == 0) begin : g_tenure_max_unused
    end
`endif

    // Next-state, next-grant and round-robin pointer decision.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        arbitrate = 1'b0;
        case (state)
            PARK: arbitrate = boundary;
            OWN: begin
                if (owner_locked) begin
                    state_nxt = LOCK;
                end else begin
                    arbitrate = boundary;
                end
            end
            LOCK: arbitrate = !owner_locked && boundary;
            default: begin
                state_nxt = PARK;
                grant_nxt = PARK_GRANT;
            end
        endcase
        if (arbitrate) begin
            if (pick_valid) begin
                grant_nxt = pick_oh;
                last_nxt  = pick_idx;
                state_nxt = OWN;
            end else if (owner_keep) begin
                state_nxt = OWN;
            end else begin
                grant_nxt = PARK_GRANT;
                state_nxt = PARK;
            end
        end
    end

    // Arbiter state and ownership pipeline; everything holds while HREADY=0.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= PARK;
            grant     <= PARK_GRANT;
            last      <= '0;
            HMASTER   <= '0;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last      <= last_nxt;
            HMASTER   <= MASTER_ID_W'(onehot_to_idx(8'(grant)));
            HMASTLOCK <= owner_locked;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: the stimulus process pushes the
// hand-computed outputs expected after each edge; a monitor pops and compares.
module tb_ahb_arbiter;

    logic       HCLK;
    logic       HRESET;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;

    typedef struct {
        string      name;
        logic [2:0] g;
        logic [1:0] m;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ahb_arbiter #(
        .NUM_MASTERS (3),
        .MASTER_ID_W (2),
        .TENURE_MAX  (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Drive one cycle of inputs and queue the outputs expected after its edge.
    task automatic step(input string nm, input logic rst, input logic [2:0] req,
                        input logic [2:0] lk, input logic [1:0] tr, input logic rdy,
                        input logic [2:0] eg, input logic [1:0] em, input logic el);
        exp_t e;
        HRESET  = rst;
        HBUSREQ = req;
        HLOCK   = lk;
        HTRANS  = tr;
        HREADY  = rdy;
        e.name = nm;
        e.g    = eg;
        e.m    = em;
        e.l    = el;
        exp_q.push_back(e);
        @(negedge HCLK);
    endtask

    // Monitor: compare DUT outputs 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge HCLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (HGRANT !== e.g || HMASTER !== e.m || HMASTLOCK !== e.l) begin
                    errors++;
                    $display("FAIL %s: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                             e.name, HGRANT, HMASTER, HMASTLOCK, e.g, e.m, e.l);
                end
                checks++;
                if (!$onehot(HGRANT)) begin
                    errors++;
                    $display("FAIL %s_onehot: got grant=%b, want exactly one bit set", e.name, HGRANT);
                end
            end
        end
    end

    initial begin
        HRESET  = 1'b1;
        HBUSREQ = 3'b000;
        HLOCK   = 3'b000;
        HTRANS  = IDL;
        HREADY  = 1'b1;
        @(negedge HCLK);

        // Reset and idle parking on master 0
        step("reset", 1, 3'b000, 3'b000, IDL, 1, 3'b001, 2'd0, 0);
        for (int i = 0; i < 10; i++) step("park_idle", 0, 3'b000, 3'b000, IDL, 1, 3'b001, 2'd0, 0);

        // First grant from park, HMASTER one cycle later, hand-off on drop
        step("grant_m1",     0, 3'b110, 3'b000, IDL, 1, 3'b010, 2'd0, 0);
        step("m1_hold_seq",  0, 3'b110, 3'b000, SQ,  1, 3'b010, 2'd1, 0);
        step("m1_drop_to_2", 0, 3'b100, 3'b000, IDL, 1, 3'b100, 2'd1, 0);
        step("all_drop_park",0, 3'b000, 3'b000, IDL, 1, 3'b001, 2'd2, 0);

        // Round-robin rotation with everyone requesting
        step("rr_m0", 0, 3'b111, 3'b000, IDL, 1, 3'b001, 2'd0, 0);
        step("rr_m1", 0, 3'b111, 3'b000, IDL, 1, 3'b010, 2'd0, 0);
        step("rr_m2", 0, 3'b111, 3'b000, IDL, 1, 3'b100, 2'd1, 0);
        step("rr_w0", 0, 3'b111, 3'b000, IDL, 1, 3'b001, 2'd2, 0);
        step("rr_w1", 0, 3'b111, 3'b000, IDL, 1, 3'b010, 2'd0, 0);

        // Locked sequence by master 2
        step("lock_grant2", 0, 3'b111, 3'b100, IDL, 1, 3'b100, 2'd1, 0);
        step("lock_enter",  0, 3'b111, 3'b100, NSQ, 1, 3'b100, 2'd2, 1);
        for (int i = 0; i < 8; i++) step("lock_seq", 0, 3'b111, 3'b100, SQ, 1, 3'b100, 2'd2, 1);
        step("lock_release", 0, 3'b111, 3'b000, IDL, 1, 3'b001, 2'd2, 0);

        // HREADY stall during master 1 tenure
        step("stall_grant1", 0, 3'b010, 3'b000, IDL, 1, 3'b010, 2'd0, 0);
        step("stall_own1",   0, 3'b010, 3'b000, NSQ, 1, 3'b010, 2'd1, 0);
        for (int i = 0; i < 5; i++) step("stall_frozen", 0, 3'b011, 3'b000, NSQ, 0, 3'b010, 2'd1, 0);
        step("stall_seq_hold", 0, 3'b011, 3'b000, SQ,  1, 3'b010, 2'd1, 0);
        step("stall_handoff",  0, 3'b011, 3'b000, NSQ, 1, 3'b001, 2'd1, 0);

        // Reset mid-transfer with HREADY low; pointer must return to 0
        step("pre_rst_m1",   0, 3'b011, 3'b000, IDL, 1, 3'b010, 2'd0, 0);
        step("rst_stalled",  1, 3'b111, 3'b111, SQ,  0, 3'b001, 2'd0, 0);
        step("post_rst_park",0, 3'b000, 3'b000, IDL, 1, 3'b001, 2'd0, 0);
        step("post_rst_ptr", 0, 3'b110, 3'b000, IDL, 1, 3'b010, 2'd0, 0);

        // Master 1 streams; master 2 joins mid-burst and waits for NONSEQ
        step("ten_b1", 0, 3'b010, 3'b000, NSQ, 1, 3'b010, 2'd1, 0);
        step("ten_b2", 0, 3'b010, 3'b000, SQ,  1, 3'b010, 2'd1, 0);
        step("ten_b3", 0, 3'b010, 3'b000, SQ,  1, 3'b010, 2'd1, 0);
        step("ten_b4", 0, 3'b010, 3'b000, SQ,  1, 3'b010, 2'd1, 0);
        step("ten_seq_a", 0, 3'b110, 3'b000, SQ, 1, 3'b010, 2'd1, 0);
        step("ten_seq_b", 0, 3'b110, 3'b000, SQ, 1, 3'b010, 2'd1, 0);
        step("ten_nonseq_handoff", 0, 3'b110, 3'b000, NSQ, 1, 3'b100, 2'd1, 0);

        // Lone master 2 streaming NONSEQ beats
        step("solo_b1", 0, 3'b100, 3'b000, NSQ, 1, 3'b100, 2'd2, 0);
        step("solo_b2", 0, 3'b100, 3'b000, NSQ, 1, 3'b100, 2'd2, 0);
        step("solo_b3", 0, 3'b100, 3'b000, NSQ, 1, 3'b100, 2'd2, 0);
        step("solo_b4", 0, 3'b100, 3'b000, NSQ, 1, 3'b100, 2'd2, 0);
`ifdef ARB_TENURE_LIMIT_EN
        step("solo_limit", 0, 3'b100, 3'b000, NSQ, 1, 3'b001, 2'd2, 0);
`else
        step("solo_keep",  0, 3'b100, 3'b000, NSQ, 1, 3'b100, 2'd2, 0);
`endif

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge HCLK);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
